bsg_down_out_seq: RTL and testbench
===================================

Name: bsg_down_out_seq

Overview:
Core-side sequencer for the downstream output path of the off-chip link. It drains 8-bit beats from the downstream receive FIFO and assembles four of them into the two 16-bit halves core_data0/core_data1. It then presents the 32-bit word {core_data1, core_data0} to the core with a valid/ready handshake. It returns flow-control tokens to the I/O side in batches of consumed beats.

Parameters:
PTR_WIDTH, 7, width of read pointer; pointer wraps modulo 2**PTR_WIDTH
TOKEN_BATCH, 8, beats consumed per io_token_out pulse; legal range 1..2**PTR_WIDTH
WCNT_WIDTH, 16, width of delivered-word counter

Ports:
clk  in  1  sole clock (core clock domain)
rst  in  1  asynchronous, active-low reset
en  in  1  sequencer enable; 0 stalls FIFO reads, held word stays presented
flush  in  1  synchronous abort of partial/held word
fifo_valid_i  in  1  receive FIFO has a beat
fifo_data_i  in  8  receive FIFO head beat
fifo_yumi_o  out  1  beat consumed this cycle (combinational)
core_ready  in  1  core accepts word
core_valid_out  out  1  word valid (registered)
core_data_out  out  32  assembled word {core_data1, core_data0} (registered)
core_data0  out  16  low half under assembly
core_data1  out  16  high half under assembly
io_token_out  out  1  one-cycle token pulse to I/O side (registered)
rptr  out  PTR_WIDTH  FIFO read pointer
word_cnt  out  WCNT_WIDTH  words delivered to core, wraps

Behaviour:
- Reset (rst low, async): state=COLLECT, byte_cnt=0, tok_cnt=0. All outputs 0: core_valid_out, core_data_out, core_data0, core_data1, io_token_out, rptr, word_cnt.
- States: COLLECT (byte_cnt 0..3), PRESENT.
- COLLECT:
  - fifo_yumi_o = en & fifo_valid_i & ~flush.
  - On yumi the beat is stored by byte_cnt: 0→core_data0[7:0], 1→core_data0[15:8], 2→core_data1[7:0], 3→core_data1[15:8].
  - On the yumi with byte_cnt=3, the FSM moves to PRESENT. core_data_out is loaded with {core_data1, core_data0} including the new beat, and core_valid_out is 1 the next cycle.
  - Latency: 4th beat consumed in cycle N → core_valid_out=1 in cycle N+1.
- PRESENT:
  - fifo_yumi_o=0. core_valid_out and core_data_out hold stable until handshake; en=0 does not drop a held word.
  - Handshake (core_valid_out & core_ready) in cycle M → core_valid_out=0 in M+1, word_cnt+1, byte_cnt=0, COLLECT. The earliest next yumi is M+1 (no same-cycle overlap).
  - core_data0/core_data1 keep their last values until overwritten.
- flush=1 has top priority:
  - Next cycle: COLLECT, byte_cnt=0, core_valid_out=0, word dropped, word_cnt unchanged. No yumi in the flush cycle.
  - A handshake coincident with flush is not counted.
  - rptr, tok_cnt and core_data0/core_data1 are unaffected.
- rptr: +1 on every yumi, wraps 2**PTR_WIDTH-1→0.
- Tokens:
  - tok_cnt increments on every yumi. When a yumi occurs with tok_cnt=TOKEN_BATCH-1, tok_cnt→0 and io_token_out=1 for exactly the next cycle.
  - Tokens count consumed beats regardless of flush.
  - TOKEN_BATCH=1 gives a pulse after every yumi; back-to-back yumis give a continuously high io_token_out.
- word_cnt wraps at 2**WCNT_WIDTH.
- Reset asserted mid-word or mid-PRESENT: immediate return to reset values. No residual token pulse; partial word discarded.

Test Plan:
- Beats 0x11,0x22,0x33,0x44 on consecutive cycles, core_ready=1 → core_valid_out high one cycle after 4th yumi with core_data_out=0x44332211. Next cycle valid=0, word_cnt=1.
- Same beats, core_ready=0 for 5 cycles, then 1 → data held at 0x44332211 for 5 cycles, fifo_yumi_o=0 throughout, single handshake.
- 130 beats consumed → rptr wraps 127→0→2. io_token_out pulses 16 times (after beats 8,16,…,128), each exactly one cycle wide.
- 2 beats then flush=1 → byte_cnt=0, next 4 beats 0xA1..0xA4 give 0xA4A3A2A1. rptr=6, no stale bytes in core_data_out.
- Word held in PRESENT, flush=1 with core_ready=1 same cycle → core_valid_out=0 next cycle, word_cnt unchanged.
- rst driven low asynchronously mid-collection (between clock edges) → all outputs 0 immediately. After release, first 4 beats form a correct word.

Source files
------------

// File: rtl/bsg_down_out_seq.sv
// bsg_down_out_seq
// Core-side sequencer for the downstream output path of the off-chip link.
// Drains 8-bit beats from the receive FIFO and packs four of them into a
// 32-bit word, {core_data1, core_data0}, which it presents to the core with
// a valid/ready handshake. For every TOKEN_BATCH beats consumed it sends one
// flow-control token back to the I/O side.
module bsg_down_out_seq #(
    parameter int PTR_WIDTH   = 7,
    parameter int TOKEN_BATCH = 8,
    parameter int WCNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,            // asynchronous, active-low
    input  logic                  en,
    input  logic                  flush,
    input  logic                  fifo_valid_i,
    input  logic [7:0]            fifo_data_i,
    output logic                  fifo_yumi_o,
    input  logic                  core_ready,
    output logic                  core_valid_out,
    output logic [31:0]           core_data_out,
    output logic [15:0]           core_data0,
    output logic [15:0]           core_data1,
    output logic                  io_token_out,
    output logic [PTR_WIDTH-1:0]  rptr,
    output logic [WCNT_WIDTH-1:0] word_cnt
);

    localparam logic [0:0] COLLECT = 1'b0;
    localparam logic [0:0] PRESENT = 1'b1;

    // The token counter only has to count 0..TOKEN_BATCH-1.
    localparam int TOK_W = ($clog2(TOKEN_BATCH) > 0) ? $clog2(TOKEN_BATCH) : 1;
    localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(TOKEN_BATCH - 1);

    logic [0:0]            state_reg, state_next;
    logic [1:0]            byte_cnt_reg, byte_cnt_next;
    logic [TOK_W-1:0]      tok_cnt_reg, tok_cnt_next;
    logic                  valid_reg, valid_next;
    logic [31:0]           data_out_reg, data_out_next;
    logic                  token_reg, token_next;
    logic [PTR_WIDTH-1:0]  rptr_reg, rptr_next;
    logic [WCNT_WIDTH-1:0] word_cnt_reg, word_cnt_next;

    logic                  yumi;
    logic                  handshake;
    logic [31:0]           lanes;        // {core_data1, core_data0} as currently assembled

    // A beat is taken only while collecting. Flush blocks the read so that no
    // beat is lost in the cycle the partial word is discarded.
    assign yumi      = (state_reg == COLLECT) & en & fifo_valid_i & ~flush;
    assign handshake = valid_reg & core_ready;

    // One register per byte lane. Lane gi captures the beat consumed while
    // byte_cnt == gi. Lanes are not cleared by flush; they keep their value
    // until the next word overwrites them.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_reg;

            // Capture the incoming beat into this lane when its slot comes up
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lane_reg <= 8'h00;
                end else if (yumi && (byte_cnt_reg == 2'(gi))) begin
                    lane_reg <= fifo_data_i;
                end
            end

            assign lanes[gi*8 +: 8] = lane_reg;
        end
    endgenerate

    // Next-state logic for the collect/present sequencer and the word counter
    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        valid_next    = valid_reg;
        data_out_next = data_out_reg;
        word_cnt_next = word_cnt_reg;

        if (flush) begin
            // Drop whatever is partial or held. A coincident handshake is
            // not counted as a delivered word.
            state_next    = COLLECT;
            byte_cnt_next = 2'd0;
            valid_next    = 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (yumi) begin
                        if (byte_cnt_reg == 2'd3) begin
                            // The fourth beat goes straight into the output
                            // word so it is valid on the very next cycle.
                            state_next    = PRESENT;
                            byte_cnt_next = 2'd0;
                            valid_next    = 1'b1;
                            data_out_next = {fifo_data_i, lanes[23:0]};
                        end else begin
                            byte_cnt_next = byte_cnt_reg + 2'd1;
                        end
                    end
                end
                PRESENT: begin
                    // The word is held regardless of en until the core takes it
                    if (handshake) begin
                        state_next    = COLLECT;
                        byte_cnt_next = 2'd0;
                        valid_next    = 1'b0;
                        word_cnt_next = word_cnt_reg + WCNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_next    = COLLECT;
                    byte_cnt_next = 2'd0;
                    valid_next    = 1'b0;
                end
            endcase
        end
    end

    // Read pointer and token batching follow consumed beats only; flush does
    // not touch them because the beats really were taken from the FIFO.
    always_comb begin
        rptr_next    = rptr_reg;
        tok_cnt_next = tok_cnt_reg;
        token_next   = 1'b0;
        if (yumi) begin
            rptr_next = rptr_reg + PTR_WIDTH'(1);
            if (tok_cnt_reg == TOK_LAST) begin
                tok_cnt_next = '0;
                token_next   = 1'b1;
            end else begin
                tok_cnt_next = tok_cnt_reg + TOK_W'(1);
            end
        end
    end

    // State register bank with asynchronous active-low clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= COLLECT;
            byte_cnt_reg <= 2'd0;
            tok_cnt_reg  <= '0;
            valid_reg    <= 1'b0;
            data_out_reg <= 32'h0;
            token_reg    <= 1'b0;
            rptr_reg     <= '0;
            word_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            byte_cnt_reg <= byte_cnt_next;
            tok_cnt_reg  <= tok_cnt_next;
            valid_reg    <= valid_next;
            data_out_reg <= data_out_next;
            token_reg    <= token_next;
            rptr_reg     <= rptr_next;
            word_cnt_reg <= word_cnt_next;
        end
    end

    assign fifo_yumi_o    = yumi;
    assign core_valid_out = valid_reg;
    assign core_data_out  = data_out_reg;
    assign core_data0     = lanes[15:0];
    assign core_data1     = lanes[31:16];
    assign io_token_out   = token_reg;
    assign rptr           = rptr_reg;
    assign word_cnt       = word_cnt_reg;

endmodule

// File: tb/tb_bsg_down_out_seq.sv
// Testbench for bsg_down_out_seq: directed scenarios plus a randomized run,
// all checked against a transaction-level model of the sequencer.
module tb_bsg_down_out_seq;

    localparam int PTR_WIDTH   = 7;
    localparam int TOKEN_BATCH = 8;
    localparam int WCNT_WIDTH  = 16;
    localparam int PTR_MOD     = 1 << PTR_WIDTH;
    localparam int WCNT_MOD    = 1 << WCNT_WIDTH;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  en = 1'b0;
    logic                  flush = 1'b0;
    logic                  fifo_valid_i = 1'b0;
    logic [7:0]            fifo_data_i = 8'h00;
    logic                  fifo_yumi_o;
    logic                  core_ready = 1'b0;
    logic                  core_valid_out;
    logic [31:0]           core_data_out;
    logic [15:0]           core_data0;
    logic [15:0]           core_data1;
    logic                  io_token_out;
    logic [PTR_WIDTH-1:0]  rptr;
    logic [WCNT_WIDTH-1:0] word_cnt;

    bsg_down_out_seq #(
        .PTR_WIDTH  (PTR_WIDTH),
        .TOKEN_BATCH(TOKEN_BATCH),
        .WCNT_WIDTH (WCNT_WIDTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .flush         (flush),
        .fifo_valid_i  (fifo_valid_i),
        .fifo_data_i   (fifo_data_i),
        .fifo_yumi_o   (fifo_yumi_o),
        .core_ready    (core_ready),
        .core_valid_out(core_valid_out),
        .core_data_out (core_data_out),
        .core_data0    (core_data0),
        .core_data1    (core_data1),
        .io_token_out  (io_token_out),
        .rptr          (rptr),
        .word_cnt      (word_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: beats gathered into the current word, the word on
    // offer, and totals of consumed beats / delivered words.
    int          m_nbeats;        // beats of the current word gathered so far
    logic [7:0]  m_bytes [4];     // last beat stored in each byte position
    bit          m_holding;       // a finished word is on offer to the core
    logic [31:0] m_word;
    int          m_consumed;      // beats consumed since reset
    int          m_words;         // words delivered since reset
    bit          m_token;         // token pulse expected this cycle

    // Observations gathered by step()
    bit obs_yumi;
    int tok_high;
    int tok_rise;
    bit tok_prev;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_nbeats   = 0;
        for (int i = 0; i < 4; i++) m_bytes[i] = 8'h00;
        m_holding  = 1'b0;
        m_word     = 32'h0;
        m_consumed = 0;
        m_words    = 0;
        m_token    = 1'b0;
    endtask

    task automatic check_outputs();
        check("valid",    {63'd0, core_valid_out}, {63'd0, m_holding});
        if (m_holding) check("data_out", {32'd0, core_data_out}, {32'd0, m_word});
        check("data0",    {48'd0, core_data0}, {48'd0, m_bytes[1], m_bytes[0]});
        check("data1",    {48'd0, core_data1}, {48'd0, m_bytes[3], m_bytes[2]});
        check("token",    {63'd0, io_token_out}, {63'd0, m_token});
        check("rptr",     {57'd0, rptr}, 64'(m_consumed % PTR_MOD));
        check("word_cnt", {48'd0, word_cnt}, 64'(m_words % WCNT_MOD));
    endtask

    // One clock cycle: drive inputs at the falling edge, check the read
    // strobe, let the rising edge happen, update the model, check registers.
    task automatic step(input bit e, input bit fv, input logic [7:0] fd,
                        input bit fl, input bit cr);
        bit exp_yumi;
        bit hs;
        en = e; fifo_valid_i = fv; fifo_data_i = fd; flush = fl; core_ready = cr;
        #1;
        exp_yumi = !m_holding && e && fv && !fl;
        check("yumi", {63'd0, fifo_yumi_o}, {63'd0, exp_yumi});
        obs_yumi = fifo_yumi_o;
        @(posedge clk);
        hs = m_holding && cr;
        m_token = 1'b0;
        if (exp_yumi) begin
            m_bytes[m_nbeats] = fd;
            m_nbeats++;
            m_consumed++;
            m_token = (m_consumed % TOKEN_BATCH) == 0;
            if (m_nbeats == 4) begin
                m_word    = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                m_holding = 1'b1;
                m_nbeats  = 0;
            end
        end else if (fl) begin
            m_holding = 1'b0;
            m_nbeats  = 0;
        end else if (hs) begin
            m_holding = 1'b0;
            m_words++;
            $display("word %0d delivered 0x%08h", m_words, m_word);
        end
        @(negedge clk);
        check_outputs();
        if (io_token_out) tok_high++;
        if (io_token_out && !tok_prev) tok_rise++;
        tok_prev = io_token_out;
    endtask

    task automatic do_reset();
        rst = 1'b0; en = 1'b0; fifo_valid_i = 1'b0; flush = 1'b0; core_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        tok_high = 0; tok_rise = 0; tok_prev = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        int guard;
        logic [7:0] beats [4];
        model_reset();
        tok_high = 0; tok_rise = 0; tok_prev = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_valid", {63'd0, core_valid_out}, 64'd0);
        check("rst_data",  {32'd0, core_data_out}, 64'd0);
        do_reset();

        // Basic word with core ready
        $display("test: basic word");
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33; beats[3] = 8'h44;
        for (int i = 0; i < 4; i++) step(1, 1, beats[i], 0, 1);
        check("basic_word", {32'd0, core_data_out}, 64'h44332211);
        check("basic_valid", {63'd0, core_valid_out}, 64'd1);
        step(1, 1, 8'h55, 0, 1);
        check("basic_cnt", {48'd0, word_cnt}, 64'd1);
        check("basic_drop", {63'd0, core_valid_out}, 64'd0);

        // Backpressure: word held, no reads while held
        $display("test: backpressure");
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, beats[i], 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 8'hEE, 0, 0);
            check("hold_yumi", {63'd0, obs_yumi}, 64'd0);
            check("hold_word", {32'd0, core_data_out}, 64'h44332211);
        end
        step(0, 1, 8'hEE, 0, 1);
        check("hold_cnt", {48'd0, word_cnt}, 64'd1);

        // 130 beats: pointer wrap and token pulses
        $display("test: pointer wrap and tokens");
        do_reset();
        guard = 0;
        while (m_consumed < 130 && guard < 400) begin
            step(1, 1, 8'($urandom), 0, 1);
            guard++;
        end
        check("wrap_guard", 64'(m_consumed), 64'd130);
        check("wrap_rptr", {57'd0, rptr}, 64'd2);
        for (int i = 0; i < 3; i++) step(0, 0, 8'h00, 0, 1);
        check("tok_high", 64'(tok_high), 64'd16);
        check("tok_rise", 64'(tok_rise), 64'd16);

        // Flush of a partial word
        $display("test: flush partial");
        do_reset();
        step(1, 1, 8'h01, 0, 1);
        step(1, 1, 8'h02, 0, 1);
        step(1, 1, 8'h03, 1, 1);
        check("flush_yumi", {63'd0, obs_yumi}, 64'd0);
        for (int i = 0; i < 4; i++) step(1, 1, 8'hA1 + 8'(i), 0, 1);
        check("flush_word", {32'd0, core_data_out}, 64'hA4A3A2A1);
        check("flush_rptr", {57'd0, rptr}, 64'd6);

        // Flush coincident with handshake
        $display("test: flush with handshake");
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 1, beats[i], 0, 0);
        step(1, 1, 8'h00, 0, 0);
        step(1, 1, 8'h00, 1, 1);
        check("fhs_valid", {63'd0, core_valid_out}, 64'd0);
        check("fhs_cnt", {48'd0, word_cnt}, 64'd0);

        // Asynchronous reset mid-collection
        $display("test: async reset");
        do_reset();
        step(1, 1, 8'h77, 0, 1);
        step(1, 1, 8'h88, 0, 1);
        step(1, 1, 8'h99, 0, 1);
        #3;
        rst = 1'b0;
        #1;
        check("arst_data0", {48'd0, core_data0}, 64'd0);
        check("arst_data1", {48'd0, core_data1}, 64'd0);
        check("arst_rptr",  {57'd0, rptr}, 64'd0);
        check("arst_valid", {63'd0, core_valid_out}, 64'd0);
        check("arst_token", {63'd0, io_token_out}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        tok_prev = 1'b0;
        for (int i = 0; i < 4; i++) step(1, 1, 8'hC0 + 8'(i), 0, 1);
        check("arst_word", {32'd0, core_data_out}, 64'hC3C2C1C0);

        // Randomized traffic
        $display("test: random traffic");
        do_reset();
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 8'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
